// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes, register-none
// marker and the processor run-state enum.
package y86_pkg;
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {RS_RUN, RS_HALT, RS_ERR} run_state_e;
endpackage

// File: rtl/instr_align.sv
// Combinational instruction aligner: splits the ten bytes at pc into
// Y86-64 fields, reports instruction length and illegal icode/ifun.
module instr_align
  import y86_pkg::*;
(
  input  logic [9:0][7:0] ibytes,
  output logic [3:0]      icode,
  output logic [3:0]      ifun,
  output logic [3:0]      rA,
  output logic [3:0]      rB,
  output logic [63:0]     valC,
  output logic [3:0]      len,
  output logic            ins_err
);
  logic has_reg;
  logic fn_ok;

  always_comb begin
    icode   = ibytes[0][7:4];
    ifun    = ibytes[0][3:0];
    len     = 4'd1;
    has_reg = 1'b0;
    valC    = 64'd0;
    fn_ok   = (ibytes[0][3:0] == 4'd0);
    case (icode)
      IRRMOVQ: begin len = 4'd2; has_reg = 1'b1; fn_ok = (ifun <= 4'd6); end
      IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
        len = 4'd10; has_reg = 1'b1; valC = ibytes[9:2];
      end
      IOPQ:    begin len = 4'd2; has_reg = 1'b1; fn_ok = (ifun <= 4'd3); end
      IJXX:    begin len = 4'd9; valC = ibytes[8:1]; fn_ok = (ifun <= 4'd6); end
      ICALL:   begin len = 4'd9; valC = ibytes[8:1]; end
      IPUSHQ, IPOPQ: begin len = 4'd2; has_reg = 1'b1; end
      default: ;  // halt, nop, ret and illegal codes occupy one byte
    endcase
    rA      = has_reg ? ibytes[1][7:4] : RNONE;
    rB      = has_reg ? ibytes[1][3:0] : RNONE;
    ins_err = (icode > IPOPQ) || !fn_ok;
  end
endmodule

// File: rtl/fetch_stage.sv
// SEQ fetch stage: PC register, byte-addressed instruction memory, decode
// and RUN/HALT/ERR state. Optional retire counter under FETCH_RETIRE_COUNT_EN.
module fetch_stage
  import y86_pkg::*;
#(
  parameter int          IMEM_BYTES = 1024,
  parameter logic [63:0] RESET_PC   = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] new_pc,
  input  logic        load_we,
  input  logic [63:0] load_addr,
  input  logic [7:0]  load_data,
  output logic [63:0] pc,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [2:0]  stat,
  output logic        halted
`ifdef FETCH_RETIRE_COUNT_EN
  , output logic [63:0] retired_count
`endif
);
  localparam int          AW       = $clog2(IMEM_BYTES);
  localparam logic [63:0] IMEM_LIM = 64'(IMEM_BYTES);

  logic [7:0]        imem [IMEM_BYTES];
  logic [9:0][63:0]  baddr;
  logic [9:0][7:0]   ibytes;
  logic [3:0]        len;
  logic              ins_err;
  logic              adr_err;
  logic [2:0]        fstat;
  run_state_e        state_q, state_d;
  logic [2:0]        estat_q, estat_d;
  logic [63:0]       pc_d;

  // Bytes past the end of memory read as zero; adr_err flags them instead.
  for (genvar i = 0; i < 10; i++) begin : g_byte
    assign baddr[i]  = pc + 64'(i);
    assign ibytes[i] = (baddr[i] < IMEM_LIM) ? imem[baddr[i][AW-1:0]] : 8'h00;
  end

  instr_align u_align (
    .ibytes (ibytes),
    .icode  (icode),
    .ifun   (ifun),
    .rA     (rA),
    .rB     (rB),
    .valC   (valC),
    .len    (len),
    .ins_err(ins_err)
  );

  assign valP = pc + 64'(len);
  // pc in range means pc+len-1 cannot wrap, so checking the last byte suffices.
  assign adr_err = (pc >= IMEM_LIM) || ((valP - 64'd1) >= IMEM_LIM);

  always_comb begin
    if (adr_err)             fstat = SADR;
    else if (ins_err)        fstat = SINS;
    else if (icode == IHALT) fstat = SHLT;
    else                     fstat = SAOK;
  end

  always_ff @(posedge clk) begin
    if (load_we && (load_addr < IMEM_LIM)) imem[load_addr[AW-1:0]] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RS_RUN;
      pc      <= RESET_PC;
      estat_q <= SAOK;
    end else begin
      state_q <= state_d;
      pc      <= pc_d;
      estat_q <= estat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    estat_d = estat_q;
    stat    = fstat;
    case (state_q)
      RS_RUN: begin
        if (fstat == SAOK)      pc_d = new_pc;
        else if (fstat == SHLT) state_d = RS_HALT;
        else begin
          state_d = RS_ERR;
          estat_d = fstat;
        end
      end
      RS_HALT: stat = SHLT;
      RS_ERR:  stat = estat_q;
      default: state_d = RS_ERR;
    endcase
  end

  assign halted = (state_q != RS_RUN) || (fstat != SAOK);

`ifdef FETCH_RETIRE_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)                                    retired_count <= 64'd0;
    else if (state_q == RS_RUN && fstat == SAOK)  retired_count <= retired_count + 64'd1;
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a byte-level reference model predicts
// every cycle's outputs; a negedge monitor pops and compares them.
module tb_fetch_stage;
  localparam int IMEM = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] new_pc;
  logic        load_we;
  logic [63:0] load_addr;
  logic [7:0]  load_data;
  logic [63:0] pc, valC, valP;
  logic [3:0]  icode, ifun, rA, rB;
  logic [2:0]  stat;
  logic        halted;
`ifdef FETCH_RETIRE_COUNT_EN
  logic [63:0] retired_count;
`endif

  fetch_stage dut (
    .clk(clk), .reset(reset), .new_pc(new_pc), .load_we(load_we),
    .load_addr(load_addr), .load_data(load_data), .pc(pc), .icode(icode),
    .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP), .stat(stat),
    .halted(halted)
`ifdef FETCH_RETIRE_COUNT_EN
    , .retired_count(retired_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc, valC, valP, cnt;
    logic [3:0]  icode, ifun, rA, rB;
    logic [2:0]  stat;
    logic        halted;
  } exp_t;

  // reference model state: 0=run 1=halt 2=err
  logic [7:0]  mem [IMEM];
  logic [63:0] mpc, mcnt;
  int          mst;
  logic [2:0]  mcap;
  exp_t        sb[$];
  int          ntests = 0, nfail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rd(input logic [63:0] a);
    return (a < 64'(IMEM)) ? mem[a[9:0]] : 8'h00;
  endfunction

  // Fetch status as if the machine were running at address a.
  function automatic exp_t decode(input logic [63:0] a);
    exp_t e;
    logic [7:0] b0, b1;
    int len, off, maxfn;
    logic adr, ins, regs;
    b0 = rd(a); b1 = rd(a + 64'd1);
    e.icode = b0[7:4]; e.ifun = b0[3:0];
    case (e.icode)
      4'h2, 4'h6, 4'hA, 4'hB: len = 2;
      4'h3, 4'h4, 4'h5:       len = 10;
      4'h7, 4'h8:             len = 9;
      default:                len = 1;
    endcase
    maxfn = (e.icode == 4'h2 || e.icode == 4'h7) ? 6 : (e.icode == 4'h6) ? 3 : 0;
    ins = (e.icode > 4'hB) || (int'(e.ifun) > maxfn);
    adr = 1'b0;
    for (int k = 0; k < len; k++) if (a + 64'(k) >= 64'(IMEM)) adr = 1'b1;
    regs = e.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    e.rA = regs ? b1[7:4] : 4'hF;
    e.rB = regs ? b1[3:0] : 4'hF;
    off = (e.icode inside {4'h3, 4'h4, 4'h5}) ? 2 : (e.icode inside {4'h7, 4'h8}) ? 1 : 0;
    e.valC = 64'd0;
    if (off != 0)
      for (int k = 0; k < 8; k++) e.valC = e.valC | (64'(rd(a + 64'(off + k))) << (8 * k));
    e.valP = a + 64'(len);
    e.pc = a;
    e.stat = adr ? 3'd3 : ins ? 3'd4 : (e.icode == 4'h0) ? 3'd2 : 3'd1;
    e.halted = 1'b0;
    e.cnt = 64'd0;
    return e;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e = decode(mpc);
    e.halted = (mst != 0) || (e.stat != 3'd1);
    if (mst == 1) e.stat = 3'd2;
    else if (mst == 2) e.stat = mcap;
    e.cnt = mcnt;
    return e;
  endfunction

  // One clock: drive, predict pre-edge outputs, clock, advance model.
  task automatic step(input logic rst, input logic [63:0] npc, input logic we,
                      input logic [63:0] la, input logic [7:0] ld, input bit push);
    exp_t d;
    reset = rst; new_pc = npc; load_we = we; load_addr = la; load_data = ld;
    if (push) sb.push_back(model_out());
    d = decode(mpc);
    @(posedge clk);
    if (rst) begin
      mpc = 64'd0; mst = 0; mcnt = 64'd0; mcap = 3'd1;
    end else if (mst == 0) begin
      if (d.stat == 3'd1) begin mpc = npc; mcnt = mcnt + 64'd1; end
      else if (d.stat == 3'd2) mst = 1;
      else begin mst = 2; mcap = d.stat; end
    end
    if (we && la < 64'(IMEM)) mem[la[9:0]] = ld;
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pc", pc, e.pc);
      chk("icode", 64'(icode), 64'(e.icode));
      chk("ifun", 64'(ifun), 64'(e.ifun));
      chk("rA", 64'(rA), 64'(e.rA));
      chk("rB", 64'(rB), 64'(e.rB));
      chk("valC", valC, e.valC);
      chk("valP", valP, e.valP);
      chk("stat", 64'(stat), 64'(e.stat));
      chk("halted", 64'(halted), 64'(e.halted));
`ifdef FETCH_RETIRE_COUNT_EN
      chk("retired_count", retired_count, e.cnt);
`endif
    end
  end

  function automatic logic [7:0] rbyte();
    if ($urandom_range(0, 3) == 0) return 8'($urandom);
    return {4'($urandom_range(0, 11)), 4'($urandom_range(0, 2))};
  endfunction

  logic [7:0] prog [10];

  initial begin
    exp_t e;
    prog = '{8'h30, 8'hF4, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < IMEM; i++) mem[i] = 8'h00;
    mpc = 0; mst = 0; mcnt = 0; mcap = 3'd1;
    // Clear memory and place irmovq $1,%rsp at 0, all while in reset.
    for (int i = 0; i < IMEM; i++)
      step(1'b1, 64'd0, 1'b1, 64'(i), (i < 10) ? prog[i] : 8'h00, i != 0);
    step(1'b1, 64'd0, 1'b0, 64'd0, 8'h00, 1'b1);
    chk("irmovq icode", 64'(icode), 64'h3);
    chk("irmovq rA", 64'(rA), 64'hF);
    chk("irmovq rB", 64'(rB), 64'h4);
    chk("irmovq valC", valC, 64'd1);
    chk("irmovq valP", valP, 64'd10);
    chk("irmovq stat", 64'(stat), 64'd1);
    step(1'b0, 64'd5, 1'b0, 64'd0, 8'h00, 1'b1);
    chk("pc after AOK", pc, 64'd5);
    chk("halt stat", 64'(stat), 64'd2);
    chk("halt halted", 64'(halted), 64'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 64'($urandom), 1'b0, 64'd0, 8'h00, 1'b1);
    chk("HALT pc hold", pc, 64'd5);
    chk("HALT stat", 64'(stat), 64'd2);
    // Reset from HALT, and load 0xC0 over byte 0 during that reset.
    step(1'b1, 64'd0, 1'b1, 64'd0, 8'hC0, 1'b1);
    chk("reset pc", pc, 64'd0);
    chk("C0 stat INS", 64'(stat), 64'd4);
    step(1'b0, 64'd77, 1'b0, 64'd0, 8'h00, 1'b1);
    chk("ERR pc hold", pc, 64'd0);
    chk("ERR stat held", 64'(stat), 64'd4);
    step(1'b1, 64'd0, 1'b1, 64'd0, 8'h27, 1'b1);
    step(1'b1, 64'd0, 1'b0, 64'd0, 8'h00, 1'b1);
    chk("27 stat INS", 64'(stat), 64'd4);
    // Address bounds: irmovq at 1020 runs off the end; nop at 1023 fits.
    step(1'b1, 64'd0, 1'b1, 64'd1020, 8'h30, 1'b1);
    step(1'b1, 64'd0, 1'b1, 64'd0, 8'h30, 1'b1);
    step(1'b0, 64'd1020, 1'b1, 64'd1023, 8'h10, 1'b1);
    chk("ADR stat", 64'(stat), 64'd3);
    step(1'b1, 64'd0, 1'b0, 64'd0, 8'h00, 1'b1);
    step(1'b0, 64'd1023, 1'b0, 64'd0, 8'h00, 1'b1);
    chk("nop@1023 stat", 64'(stat), 64'd1);
    chk("nop@1023 valP", valP, 64'd1024);
    // Same-cycle load: pc=0 sees the old byte this cycle, the new one next.
    step(1'b1, 64'd0, 1'b0, 64'd0, 8'h00, 1'b1);
    step(1'b1, 64'd0, 1'b1, 64'd0, 8'h10, 1'b1);
    chk("load visible next cycle", 64'(icode), 64'h1);
`ifdef FETCH_RETIRE_COUNT_EN
    step(1'b1, 64'd0, 1'b1, 64'd1, 8'h10, 1'b1);
    step(1'b1, 64'd0, 1'b1, 64'd2, 8'h10, 1'b1);
    step(1'b1, 64'd0, 1'b1, 64'd3, 8'h00, 1'b1);
    for (int i = 1; i < 8; i++) step(1'b0, 64'(i), 1'b0, 64'd0, 8'h00, 1'b1);
    chk("retired nop x3", retired_count, 64'd3);
`endif
    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [63:0] npc, la;
      bit rst, we;
      int r;
      e = model_out();
      rst = (mst != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
      r = $urandom_range(0, 9);
      npc = (r < 7) ? e.valP : (r < 9) ? 64'($urandom_range(0, 1040)) : {$urandom, $urandom};
      we = ($urandom_range(0, 9) < 4);
      la = ($urandom_range(0, 19) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 1100));
      step(rst, npc, we, la, rbyte(), 1'b1);
    end
    @(negedge clk);
    #1;
    chk("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
